irq_controller: RTL and testbench
=================================

Name: irq_controller

Overview:
- Downstream consumer of the timer block and all other peripheral interrupt sources.
- Latches single-cycle interrupt pulses into per-source pending flags.
- Applies per-source enables and per-group 2-bit priorities, then arbitrates one winning vector.
- Presents that vector to the CPU with a request/acknowledge handshake. Registers are memory-mapped at 0x2020-0x202F on the shared peripheral bus.

Parameters:
- NUM_IRQ, 32, number of interrupt sources; must be a multiple of 8, maximum 32.
- BASE_ADDR, 24'h2020, first register address.

Ports:
- clk  input  1  system clock; one clock domain. Reset is synchronous and active-low.
- reset  input  1  synchronous reset, active-low; 0 = reset, sampled on posedge clk.
- bus_write  input  1  register write strobe, sampled on posedge clk.
- bus_read  input  1  register read strobe; informational only, reads have no side effects.
- bus_address_in  input  24  register address.
- bus_data_in  input  8  write data.
- bus_data_out  output  8  combinational read data; 0 for unmapped addresses.
- irq_in  input  NUM_IRQ  one-cycle interrupt pulses; timer irqs[2:0] connect to sources 0-2.
- cpu_ilevel  input  2  current CPU interrupt mask level.
- irq_req  output  1  interrupt request to the CPU.
- irq_vector  output  5  winning source index, stable while irq_req=1.
- irq_level  output  2  group priority of the winning source.
- irq_ack  input  1  one-cycle CPU acknowledge.

Behaviour:
- Source i belongs to group g = i/2, giving 16 groups.
- Register map (offsets from BASE_ADDR):
  - +0..+3 PRIO: group g occupies byte g/4, bits [2*(g%4)+1 : 2*(g%4)]. Priority 0 = group disabled.
  - +4..+7 ENABLE: source i at byte i/8, bit i%8.
  - +8..+B PENDING: read returns the flags. Writing 1 clears the flag; writing 0 has no effect.
  - Writes to unmapped addresses and to bytes beyond NUM_IRQ are ignored.
- Reset values: PRIO=0, ENABLE=0, PENDING=0, irq_req=0, irq_vector=0, irq_level=0, state=IDLE.
- Pending set:
  - irq_in[i]=1 at posedge N sets pending[i], visible at N+1.
  - Pending sets regardless of ENABLE.
  - If set and write-1-clear hit the same bit in the same cycle, set wins.
- Eligibility: pending & enable & prio(group)!=0 & prio(group) > cpu_ilevel.
- Arbitration (combinational): highest prio wins; ties go to the lowest source index.
- FSM:
  - IDLE: if any source is eligible, latch irq_vector and irq_level and go to REQ. irq_req rises at N+2 after the pulse.
  - REQ: irq_req=1; vector and level are frozen, with no preemption by higher-priority arrivals.
    - irq_ack=1: clear pending[irq_vector], drop irq_req, go to DONE.
    - The latched source becomes ineligible before ack (software clear, enable or prio change, cpu_ilevel raised): withdraw irq_req, go to IDLE.
    - If ack and the withdrawal condition occur in the same cycle, ack wins.
  - DONE: one cycle with irq_req=0, guaranteeing at least one low cycle between requests; then IDLE.
- irq_ack outside REQ is ignored.
- If a new pulse arrives on the acked source in the same cycle as its ack-clear, the flag stays set.
- Reset asserted mid-handshake: next posedge returns everything to reset values; an in-flight request is lost.

Optional Feature:
- Macro IRQ_FORCE_EN.
- Defined: offsets +C..+F form a write-only FORCE register. Writing 1 sets the corresponding pending bit, merged with hardware sets. Reads return 0.
- Undefined: +C..+F are unmapped and writes there are ignored.

Decomposition:
- Package irq_pkg: NUM_GROUPS, register offset constants (PRIO_OFS, ENABLE_OFS, PENDING_OFS, FORCE_OFS), and enum irq_state_t {IDLE, REQ, DONE}.
- Sub-module irq_arbiter: purely combinational. Takes eligible mask and priorities; returns found, vector, level.

Test Plan:
- PRIO group0=3, ENABLE bit1=1, cpu_ilevel=0, pulse irq_in[1] at cycle N -> irq_req=1 at N+2, vector=1, level=3; ack -> pending[1]=0, irq_req low for at least 1 cycle.
- Sources 2 (prio 1) and 5 (prio 2) pulsed together -> vector=5 first; after its ack, vector=2.
- Sources 4 and 5 pulsed together, same group -> vector=4.
- In REQ with vector=3, write 0x08 to PENDING byte 0 before ack -> irq_req drops the next cycle, FSM returns to IDLE.
- cpu_ilevel=2 with source prio 2 pending -> no request; lower cpu_ilevel to 1 -> request 1 cycle later.
- IRQ_FORCE_EN defined: write 0x01 to +C -> pending[0]=1; undefined: same write leaves PENDING at 0.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared constants and types for the interrupt controller.
//   NUM_GROUPS   : number of two-source priority groups at the maximum source count
//   *_OFS        : register offsets from BASE_ADDR
//   irq_state_t  : request/acknowledge handshake state
package irq_pkg;
    localparam int NUM_GROUPS = 16;

    localparam logic [3:0] PRIO_OFS    = 4'h0;
    localparam logic [3:0] ENABLE_OFS  = 4'h4;
    localparam logic [3:0] PENDING_OFS = 4'h8;
    localparam logic [3:0] FORCE_OFS   = 4'hC;

    typedef enum logic [1:0] {IDLE, REQ, DONE} irq_state_t;
endpackage

// File: rtl/irq_arbiter.sv
// Combinational winner selection among eligible interrupt sources.
//   eligible : per-source eligibility mask
//   prio     : packed 2-bit group priorities, group g at [2g+1:2g] (source i is in group i/2)
//   found    : at least one source is eligible
//   vector   : winning source index
//   level    : priority of the winning source's group
// Highest priority wins; ties go to the lowest source index.
module irq_arbiter #(
    parameter int NUM_IRQ = 32
) (
    input  logic [NUM_IRQ-1:0] eligible,
    input  logic [NUM_IRQ-1:0] prio,
    output logic               found,
    output logic [4:0]         vector,
    output logic [1:0]         level
);
    always_comb begin
        found  = 1'b0;
        vector = '0;
        level  = '0;
        // Ascending scan with a strict compare keeps the lowest index on ties.
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (eligible[i] && (!found || prio[2*(i/2) +: 2] > level)) begin
                found  = 1'b1;
                vector = 5'(i);
                level  = prio[2*(i/2) +: 2];
            end
        end
    end
endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: latches one-cycle interrupt pulses into pending flags,
// applies per-source enables and per-group priorities, arbitrates one vector
// and presents it to the CPU with a request/acknowledge handshake.
//   clk, reset            : clock, synchronous active-low reset
//   bus_*                 : register bus (PRIO +0..3, ENABLE +4..7, PENDING +8..B W1C)
//   irq_in                : per-source interrupt pulses
//   cpu_ilevel            : CPU mask level; only priorities above it are requested
//   irq_req/vector/level  : request to the CPU, frozen while irq_req=1
//   irq_ack               : one-cycle acknowledge, honoured only while requesting
// Build option IRQ_FORCE_EN: +C..+F become a write-only FORCE register that sets
// pending bits; without it those addresses are unmapped.
module irq_controller
    import irq_pkg::*;
#(
    parameter int          NUM_IRQ   = 32,
    parameter logic [23:0] BASE_ADDR = 24'h2020
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               bus_write,
    input  logic               bus_read,
    input  logic [23:0]        bus_address_in,
    input  logic [7:0]         bus_data_in,
    output logic [7:0]         bus_data_out,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [1:0]         cpu_ilevel,
    output logic               irq_req,
    output logic [4:0]         irq_vector,
    output logic [1:0]         irq_level,
    input  logic               irq_ack
);
    localparam int NUM_BYTES = NUM_IRQ / 8;

    logic [NUM_IRQ-1:0] prio_q, prio_d;
    logic [NUM_IRQ-1:0] enable_q, enable_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    irq_state_t         state_q, state_d;
    logic               req_q, req_d;
    logic [4:0]         vec_q, vec_d;
    logic [1:0]         lvl_q, lvl_d;

    logic [NUM_IRQ-1:0] eligible;
    logic               arb_found;
    logic [4:0]         arb_vec;
    logic [1:0]         arb_lvl;
    logic [1:0]         grp_prio;

    // Reads have no side effects, so the read strobe is not needed.
    logic unused_bus_read;
    assign unused_bus_read = bus_read;

    // Decode: full-width offset so aliases outside the 16-byte window never hit.
    logic [23:0] ofs;
    logic        in_win;
    logic [1:0]  lane;
    assign ofs    = bus_address_in - BASE_ADDR;
    assign in_win = (ofs < 24'd16);
    assign lane   = ofs[1:0];

    always_comb begin
        bus_data_out = '0;
        for (int b = 0; b < NUM_BYTES; b++) begin
            if (in_win && lane == b[1:0]) begin
                if (ofs[3:2] == PRIO_OFS[3:2])    bus_data_out = prio_q[8*b +: 8];
                if (ofs[3:2] == ENABLE_OFS[3:2])  bus_data_out = enable_q[8*b +: 8];
                if (ofs[3:2] == PENDING_OFS[3:2]) bus_data_out = pending_q[8*b +: 8];
            end
        end
    end

    always_comb begin
        prio_d    = prio_q;
        enable_d  = enable_q;
        pending_d = pending_q;
        for (int b = 0; b < NUM_BYTES; b++) begin
            if (bus_write && in_win && lane == b[1:0]) begin
                if (ofs[3:2] == PRIO_OFS[3:2])    prio_d[8*b +: 8]   = bus_data_in;
                if (ofs[3:2] == ENABLE_OFS[3:2])  enable_d[8*b +: 8] = bus_data_in;
                if (ofs[3:2] == PENDING_OFS[3:2])
                    pending_d[8*b +: 8] = pending_q[8*b +: 8] & ~bus_data_in;
`ifdef IRQ_FORCE_EN
                if (ofs[3:2] == FORCE_OFS[3:2])
                    pending_d[8*b +: 8] = pending_d[8*b +: 8] | bus_data_in;
`endif
            end
        end
        if (state_q == REQ && irq_ack) pending_d[vec_q] = 1'b0;
        // Applied last: a hardware pulse beats any same-cycle clear.
        pending_d = pending_d | irq_in;
    end

    always_comb begin
        grp_prio = '0;
        eligible = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            grp_prio    = prio_q[2*(i/2) +: 2];
            eligible[i] = pending_q[i] && enable_q[i] && (grp_prio != 2'd0) && (grp_prio > cpu_ilevel);
        end
    end

    irq_arbiter #(.NUM_IRQ(NUM_IRQ)) u_arb (
        .eligible (eligible),
        .prio     (prio_q),
        .found    (arb_found),
        .vector   (arb_vec),
        .level    (arb_lvl)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        vec_d   = vec_q;
        lvl_d   = lvl_q;
        case (state_q)
            IDLE: if (arb_found) begin
                state_d = REQ;
                req_d   = 1'b1;
                vec_d   = arb_vec;
                lvl_d   = arb_lvl;
            end
            // Ack takes precedence over withdrawal; no preemption while requesting.
            REQ: if (irq_ack) begin
                state_d = DONE;
                req_d   = 1'b0;
            end else if (!eligible[vec_q]) begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
            DONE: state_d = IDLE;
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            prio_q    <= '0;
            enable_q  <= '0;
            pending_q <= '0;
            state_q   <= IDLE;
            req_q     <= 1'b0;
            vec_q     <= '0;
            lvl_q     <= '0;
        end else begin
            prio_q    <= prio_d;
            enable_q  <= enable_d;
            pending_q <= pending_d;
            state_q   <= state_d;
            req_q     <= req_d;
            vec_q     <= vec_d;
            lvl_q     <= lvl_d;
        end
    end

    assign irq_req    = req_q;
    assign irq_vector = vec_q;
    assign irq_level  = lvl_q;
endmodule

// File: tb/tb_irq_controller.sv
module tb_irq_controller;
    localparam logic [23:0] BASE = 24'h2020;

    logic        clk = 1'b0;
    logic        reset;
    logic        bus_write, bus_read;
    logic [23:0] bus_address_in;
    logic [7:0]  bus_data_in, bus_data_out;
    logic [31:0] irq_in;
    logic [1:0]  cpu_ilevel;
    logic        irq_req;
    logic [4:0]  irq_vector;
    logic [1:0]  irq_level;
    logic        irq_ack;

    int checks = 0;
    int errors = 0;
    logic [6:0] exp_q[$];   // {vector, level} expected at each rising irq_req
    logic prev_req = 1'b0;

    irq_controller #(.NUM_IRQ(32), .BASE_ADDR(24'h2020)) dut (
        .clk(clk), .reset(reset), .bus_write(bus_write), .bus_read(bus_read),
        .bus_address_in(bus_address_in), .bus_data_in(bus_data_in), .bus_data_out(bus_data_out),
        .irq_in(irq_in), .cpu_ilevel(cpu_ilevel), .irq_req(irq_req),
        .irq_vector(irq_vector), .irq_level(irq_level), .irq_ack(irq_ack)
    );

    always #5 clk = ~clk;

    // Scoreboard: every new request must match the next expected vector/level.
    always @(negedge clk) begin
        logic [6:0] e;
        if (irq_req === 1'b1 && prev_req === 1'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_req got vec=%0d lvl=%0d want no request", irq_vector, irq_level);
            end else begin
                e = exp_q.pop_front();
                if ({irq_vector, irq_level} !== e) begin
                    errors++;
                    $display("FAIL req_vector got vec=%0d lvl=%0d want vec=%0d lvl=%0d",
                             irq_vector, irq_level, e[6:2], e[1:0]);
                end
            end
        end
        prev_req = irq_req;
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic wr(input logic [23:0] a, input logic [7:0] d);
        bus_write = 1'b1; bus_address_in = a; bus_data_in = d;
        @(negedge clk);
        bus_write = 1'b0;
    endtask

    task automatic rd(input logic [23:0] a, output logic [7:0] d);
        bus_read = 1'b1; bus_address_in = a;
        #1 d = bus_data_out;
        bus_read = 1'b0;
    endtask

    task automatic pulse(input logic [31:0] m);
        irq_in = m;
        @(negedge clk);
        irq_in = '0;
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
    endtask

    task automatic wait_req(input string nm);
        int n = 0;
        while (irq_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (irq_req !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout irq_req=%b want 1", nm, irq_req);
        end
    endtask

    task automatic test_reset();
        logic [7:0] d;
        reset = 1'b0; bus_write = 0; bus_read = 0; bus_address_in = '0; bus_data_in = '0;
        irq_in = '0; cpu_ilevel = 2'd0; irq_ack = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        checks++;
        if ({irq_req, irq_vector, irq_level} !== 8'h00) begin
            errors++; $display("FAIL reset_outputs got %b want 0", {irq_req, irq_vector, irq_level});
        end
        for (int o = 0; o < 12; o++) begin
            rd(BASE + 24'(o), d);
            checks++;
            if (d !== 8'h00) begin errors++; $display("FAIL reset_reg ofs=%0d got %h want 00", o, d); end
        end
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] d;
        wr(BASE + 24'h0, 8'h03);
        wr(BASE + 24'h4, 8'h02);
        ack();   // ack in IDLE must be ignored
        checks++;
        if (irq_req !== 1'b0) begin errors++; $display("FAIL idle_ack got req=%b want 0", irq_req); end
        exp_q.push_back({5'd1, 2'd3});
        pulse(32'h2);
        checks++;
        if (irq_req !== 1'b0) begin errors++; $display("FAIL basic_early got req=%b want 0", irq_req); end
        rd(BASE + 24'h8, d);
        checks++;
        if (d !== 8'h02) begin errors++; $display("FAIL basic_pending got %h want 02", d); end
        @(negedge clk);
        checks++;
        if (irq_req !== 1'b1) begin errors++; $display("FAIL basic_latency got req=%b want 1", irq_req); end
        ack();
        checks++;
        if (irq_req !== 1'b0) begin errors++; $display("FAIL basic_drop got req=%b want 0", irq_req); end
        rd(BASE + 24'h8, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL basic_clear got %h want 00", d); end
        @(negedge clk);
        checks++;
        if (irq_req !== 1'b0) begin errors++; $display("FAIL basic_done_low got req=%b want 0", irq_req); end
    endtask

    task automatic test_priority();
        wr(BASE + 24'h0, 8'h27);   // g0=3, g1=1, g2=2
        wr(BASE + 24'h4, 8'h3E);
        exp_q.push_back({5'd5, 2'd2});
        exp_q.push_back({5'd2, 2'd1});
        pulse(32'h24);
        wait_req("prio_a"); ack();
        wait_req("prio_b"); ack();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_tie();
        exp_q.push_back({5'd4, 2'd2});
        exp_q.push_back({5'd5, 2'd2});
        pulse(32'h30);
        wait_req("tie_a"); ack();
        wait_req("tie_b"); ack();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_withdraw();
        logic [7:0] d;
        exp_q.push_back({5'd3, 2'd1});
        pulse(32'h8);
        wait_req("wd");
        wr(BASE + 24'h8, 8'h08);
        @(negedge clk);
        checks++;
        if (irq_req !== 1'b0) begin errors++; $display("FAIL withdraw_drop got req=%b want 0", irq_req); end
        rd(BASE + 24'h8, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL withdraw_pending got %h want 00", d); end
        repeat (3) @(negedge clk);
        // Back in IDLE: a fresh pulse is requested again.
        exp_q.push_back({5'd3, 2'd1});
        pulse(32'h8);
        wait_req("wd_again"); ack();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_ilevel();
        cpu_ilevel = 2'd2;
        pulse(32'h20);
        repeat (4) @(negedge clk);
        checks++;
        if (irq_req !== 1'b0) begin errors++; $display("FAIL ilevel_mask got req=%b want 0", irq_req); end
        exp_q.push_back({5'd5, 2'd2});
        cpu_ilevel = 2'd1;
        @(negedge clk);
        checks++;
        if (irq_req !== 1'b1) begin errors++; $display("FAIL ilevel_unmask got req=%b want 1", irq_req); end
        ack();
        cpu_ilevel = 2'd0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_ack_set_wins();
        logic [7:0] d;
        exp_q.push_back({5'd1, 2'd3});
        exp_q.push_back({5'd1, 2'd3});
        pulse(32'h2);
        wait_req("asw");
        irq_in = 32'h2; irq_ack = 1'b1;
        @(negedge clk);
        irq_in = '0; irq_ack = 1'b0;
        rd(BASE + 24'h8, d);
        checks++;
        if (d !== 8'h02) begin errors++; $display("FAIL ack_set_wins got %h want 02", d); end
        wait_req("asw_again"); ack();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_unmapped_force();
        logic [7:0] d;
        logic [7:0] exp_force;
`ifdef IRQ_FORCE_EN
        exp_force = 8'h01;
`else
        exp_force = 8'h00;
`endif
        wr(BASE + 24'h10, 8'hFF);
        wr(BASE - 24'h1, 8'hFF);
        rd(BASE + 24'h0, d);
        checks++;
        if (d !== 8'h27) begin errors++; $display("FAIL unmapped_alias got %h want 27", d); end
        rd(BASE + 24'h10, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL unmapped_read got %h want 00", d); end
        @(negedge clk);
        wr(BASE + 24'hC, 8'h01);
        rd(BASE + 24'h8, d);
        checks++;
        if (d !== exp_force) begin errors++; $display("FAIL force_pending got %h want %h", d, exp_force); end
        rd(BASE + 24'hC, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL force_read got %h want 00", d); end
        @(negedge clk);
        wr(BASE + 24'h8, 8'hFF);
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        exp_q.push_back({5'd3, 2'd1});
        pulse(32'h8);
        wait_req("rst_mid");
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checks++;
        if ({irq_req, irq_vector, irq_level} !== 8'h00) begin
            errors++; $display("FAIL reset_mid_out got %b want 0", {irq_req, irq_vector, irq_level});
        end
        rd(BASE + 24'h0, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL reset_mid_prio got %h want 00", d); end
        rd(BASE + 24'h8, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL reset_mid_pend got %h want 00", d); end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_tie();
        test_withdraw();
        test_ilevel();
        test_ack_set_wins();
        test_unmapped_force();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_left got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
